mac_vec_sat: RTL and testbench



---
 rtl/mac_pkg.sv | 40 ++++
 rtl/mac_sat_acc.sv | 89 ++++++++
 rtl/mac_vec_sat.sv | 142 ++++++++++++++
 tb/tb_mac_vec_sat.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared arithmetic helpers for the vector MAC: default widths and a
// width-generic saturating adder evaluated on sign-extended 64-bit operands.
package mac_pkg;

  localparam int W_IN_DEF  = 14;
  localparam int W_OUT_DEF = 28;
  localparam int SAT_W     = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic wide_t sat_max(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  // Operands must already lie within the signed range of w bits, so the exact
  // 64-bit sum leaving that range is the same as the same-sign/different-sign rule.
  function automatic logic sat_ovf(input wide_t x, input wide_t y, input int w);
    wide_t s;
    s = x + y;
    return (s > sat_max(w)) || (s < sat_min(w));
  endfunction

  function automatic wide_t sat_add(input wide_t x, input wide_t y, input int w);
    wide_t s;
    wide_t r;
    s = x + y;
    r = s;
    if (s > sat_max(w)) begin
      r = sat_max(w);
    end else if (s < sat_min(w)) begin
      r = sat_min(w);
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_sat_acc.sv
// Accumulate stage of the vector MAC: saturating accumulator, sticky overflow
// and term counter that flags the last term of each vector.
module mac_sat_acc
  import mac_pkg::*;
#(
  parameter int W_IN    = W_IN_DEF,
  parameter int W_OUT   = W_OUT_DEF,
  parameter int VEC_LEN = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       prod_vld,
  input  logic signed [2*W_IN-1:0]   prod,
  output logic signed [W_OUT-1:0]    acc,
  output logic                       ovf,
  output logic                       done
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  logic signed [W_OUT-1:0] acc_q, acc_d;
  logic signed [W_OUT-1:0] prod_ext;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  function automatic logic signed [W_OUT-1:0] acc_sat(
    input logic signed [W_OUT-1:0] x,
    input logic signed [W_OUT-1:0] y
  );
    return W_OUT'(sat_add(wide_t'(x), wide_t'(y), W_OUT));
  endfunction

  function automatic logic acc_clamped(
    input logic signed [W_OUT-1:0] x,
    input logic signed [W_OUT-1:0] y
  );
    return sat_ovf(wide_t'(x), wide_t'(y), W_OUT);
  endfunction

  // accumulate stage: first term loads, later terms add with saturation
  always_comb begin
    prod_ext = W_OUT'(prod);
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (prod_vld) begin
      if (cnt_q == '0) begin
        acc_d = prod_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_sat(acc_q, prod_ext);
        ovf_d = ovf_q | acc_clamped(acc_q, prod_ext);
      end
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign acc  = acc_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: rtl/mac_vec_sat.sv
// Pipelined saturating dot-product MAC over VEC_LEN signed operand pairs.
// Define PIPELINE_MULT_EN to register the multiplier output (latency 3 instead of 2).
module mac_vec_sat
  import mac_pkg::*;
#(
  parameter int W_IN    = W_IN_DEF,
  parameter int W_OUT   = W_OUT_DEF,
  parameter int VEC_LEN = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     valid_in,
  input  logic signed [W_IN-1:0]   a,
  input  logic signed [W_IN-1:0]   b,
  output logic signed [W_OUT-1:0]  f,
  output logic                     valid_out,
  output logic                     overflow
);

  localparam int PW = 2 * W_IN;

  if (W_OUT < 2 * W_IN) begin : g_bad_w_out
    $error("mac_vec_sat: W_OUT must be at least 2*W_IN");
  end
  if (W_OUT >= SAT_W) begin : g_bad_w_max
    $error("mac_vec_sat: W_OUT must be below the 64-bit helper width");
  end
  if (VEC_LEN < 1) begin : g_bad_len
    $error("mac_vec_sat: VEC_LEN must be at least 1");
  end

  logic signed [W_IN-1:0]  a_p1_q, a_p1_d;
  logic signed [W_IN-1:0]  b_p1_q, b_p1_d;
  logic                    vld_p1_q, vld_p1_d;
  logic signed [PW-1:0]    prod_p1;
  logic signed [PW-1:0]    prod_acc;
  logic                    vld_acc;
  logic signed [W_OUT-1:0] acc;
  logic                    acc_ovf;
  logic                    acc_done;
  logic signed [W_OUT-1:0] f_q, f_d;
  logic                    overflow_q, overflow_d;
  logic                    valid_out_q, valid_out_d;

  // stage 1: operand capture; a same-cycle valid_in survives clear
  always_comb begin
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    vld_p1_d = valid_in;
    if (valid_in) begin
      a_p1_d = a;
      b_p1_d = b;
    end
    prod_p1 = PW'(a_p1_q) * PW'(b_p1_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_p1_q   <= '0;
      b_p1_q   <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      a_p1_q   <= a_p1_d;
      b_p1_q   <= b_p1_d;
      vld_p1_q <= vld_p1_d;
    end
  end

`ifdef PIPELINE_MULT_EN
  logic signed [PW-1:0] prod_p2_q, prod_p2_d;
  logic                 vld_p2_q, vld_p2_d;

  // stage P: registered product; clear kills the term moving out of stage 1
  always_comb begin
    prod_p2_d = prod_p2_q;
    vld_p2_d  = vld_p1_q & ~clear;
    if (vld_p1_q) begin
      prod_p2_d = prod_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_p2_q <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      prod_p2_q <= prod_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  assign prod_acc = prod_p2_q;
  assign vld_acc  = vld_p2_q;
`else
  assign prod_acc = prod_p1;
  assign vld_acc  = vld_p1_q;
`endif

  mac_sat_acc #(
    .W_IN    (W_IN),
    .W_OUT   (W_OUT),
    .VEC_LEN (VEC_LEN)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .prod_vld (vld_acc),
    .prod     (prod_acc),
    .acc      (acc),
    .ovf      (acc_ovf),
    .done     (acc_done)
  );

  // output stage: result and sticky flag move together on done
  always_comb begin
    f_d         = f_q;
    overflow_d  = overflow_q;
    valid_out_d = acc_done;
    if (acc_done) begin
      f_d        = acc;
      overflow_d = acc_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q         <= '0;
      overflow_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      f_q         <= f_d;
      overflow_q  <= overflow_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign f         = f_q;
  assign overflow  = overflow_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_mac_vec_sat.sv
// Directed bench for mac_vec_sat: a VEC_LEN=4 instance plus a VEC_LEN=1 instance
// sharing the same stimulus.
module tb_mac_vec_sat;

`ifdef PIPELINE_MULT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic               clk = 1'b0;
  logic               reset, clear, valid_in;
  logic signed [13:0] a, b;
  logic signed [27:0] f, f1;
  logic               valid_out, overflow, vo1, ov1;

  int n_pass  = 0;
  int n_total = 0;

  logic signed [13:0] sa [16];
  logic signed [13:0] sb [16];
  int                 term_t [16];
  logic signed [27:0] res_f [$];
  logic               res_ov [$];
  int                 res_t [$];

  always #5 clk = ~clk;

  mac_vec_sat #(.W_IN(14), .W_OUT(28), .VEC_LEN(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in),
    .a(a), .b(b), .f(f), .valid_out(valid_out), .overflow(overflow)
  );

  mac_vec_sat #(.W_IN(14), .W_OUT(28), .VEC_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in),
    .a(a), .b(b), .f(f1), .valid_out(vo1), .overflow(ov1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_obs(inout int k);
    @(posedge clk);
    #1;
    if (valid_out === 1'b1) begin
      res_f.push_back(f);
      res_ov.push_back(overflow);
      res_t.push_back(k);
    end
    k++;
  endtask

  // Drives n terms from sa/sb (optionally with random idle gaps), then drains.
  task automatic run_stream(input int n, input bit gaps);
    int k;
    k = 0;
    res_f.delete();
    res_ov.delete();
    res_t.delete();
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        valid_in = 1'b0;
        step_obs(k);
      end
      valid_in  = 1'b1;
      a         = sa[i];
      b         = sb[i];
      term_t[i] = k;
      step_obs(k);
    end
    valid_in = 1'b0;
    repeat (LAT + 3) step_obs(k);
  endtask

  function automatic logic signed [27:0] rf(input int i);
    if (i < res_f.size()) return res_f[i];
    return 'x;
  endfunction

  function automatic logic rov(input int i);
    if (i < res_ov.size()) return res_ov[i];
    return 1'bx;
  endfunction

  function automatic int rt(input int i);
    if (i < res_t.size()) return res_t[i];
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; valid_in = 1'b0; a = '0; b = '0;
    step();
    step();
    n_total++; if (f !== 28'sd0) $display("FAIL reset_f: got %0d expected 0", f); else n_pass++;
    n_total++; if (valid_out !== 1'b0) $display("FAIL reset_vo: got %b expected 0", valid_out); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_ov: got %b expected 0", overflow); else n_pass++;
    n_total++; if (f1 !== 28'sd0) $display("FAIL reset_f1: got %0d expected 0", f1); else n_pass++;
    n_total++; if (vo1 !== 1'b0) $display("FAIL reset_vo1: got %b expected 0", vo1); else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      sa[i] = 14'(i + 1);
      sb[i] = 14'sd2;
    end
    run_stream(4, 1'b0);
    n_total++; if (res_f.size() !== 1) $display("FAIL basic_count: got %0d expected 1", res_f.size()); else n_pass++;
    n_total++; if (rf(0) !== 28'sd20) $display("FAIL basic_f: got %0d expected 20", rf(0)); else n_pass++;
    n_total++; if (rov(0) !== 1'b0) $display("FAIL basic_ov: got %b expected 0", rov(0)); else n_pass++;
    n_total++; if ((rt(0) - term_t[3]) !== LAT) $display("FAIL basic_latency: got %0d expected %0d", rt(0) - term_t[3], LAT); else n_pass++;
  endtask

  task automatic test_vec_len1();
    valid_in = 1'b1; a = 14'sd3;  b = -14'sd5;
    step();
    a = -14'sd7; b = 14'sd9;
    step();
    valid_in = 1'b0;
    repeat (LAT - 1) step();
    n_total++; if (vo1 !== 1'b1) $display("FAIL len1_vo_a: got %b expected 1", vo1); else n_pass++;
    n_total++; if (f1 !== -28'sd15) $display("FAIL len1_f_a: got %0d expected -15", f1); else n_pass++;
    n_total++; if (ov1 !== 1'b0) $display("FAIL len1_ov_a: got %b expected 0", ov1); else n_pass++;
    step();
    n_total++; if (vo1 !== 1'b1) $display("FAIL len1_vo_b: got %b expected 1", vo1); else n_pass++;
    n_total++; if (f1 !== -28'sd63) $display("FAIL len1_f_b: got %0d expected -63", f1); else n_pass++;
    step();
    n_total++; if (vo1 !== 1'b0) $display("FAIL len1_vo_end: got %b expected 0", vo1); else n_pass++;
    n_total++; if (f1 !== -28'sd63) $display("FAIL len1_f_hold: got %0d expected -63", f1); else n_pass++;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      sa[i] = (i < 4) ? 14'sd1 : -14'sd1;
      sb[i] = sa[i];
    end
    run_stream(8, 1'b0);
    n_total++; if (res_f.size() !== 2) $display("FAIL b2b_count: got %0d expected 2", res_f.size()); else n_pass++;
    n_total++; if (rf(0) !== 28'sd4) $display("FAIL b2b_f0: got %0d expected 4", rf(0)); else n_pass++;
    n_total++; if (rf(1) !== 28'sd4) $display("FAIL b2b_f1: got %0d expected 4", rf(1)); else n_pass++;
    n_total++; if ((rt(1) - rt(0)) !== 4) $display("FAIL b2b_spacing: got %0d expected 4", rt(1) - rt(0)); else n_pass++;
    n_total++; if ((rt(1) - term_t[7]) !== LAT) $display("FAIL b2b_latency: got %0d expected %0d", rt(1) - term_t[7], LAT); else n_pass++;
    for (int i = 4; i < 8; i++) begin
      sa[i] = -14'sd1;
      sb[i] = 14'sd1;
    end
    run_stream(8, 1'b0);
    n_total++; if (rf(1) !== -28'sd4) $display("FAIL b2b_neg: got %0d expected -4", rf(1)); else n_pass++;
  endtask

  task automatic test_saturation();
    logic signed [27:0] pos_max, neg_min;
    pos_max = 28'sh7FFFFFF;
    neg_min = 28'sh8000000;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        sa[i] = 14'sh2000; sb[i] = 14'sh2000;
      end else if (i < 8) begin
        sa[i] = 14'sh2000; sb[i] = 14'sd8191;
      end else begin
        sa[i] = 14'sd1;    sb[i] = 14'sd1;
      end
    end
    run_stream(12, 1'b0);
    n_total++; if (res_f.size() !== 3) $display("FAIL sat_count: got %0d expected 3", res_f.size()); else n_pass++;
    n_total++; if (rf(0) !== pos_max) $display("FAIL sat_pos_f: got %h expected %h", rf(0), pos_max); else n_pass++;
    n_total++; if (rov(0) !== 1'b1) $display("FAIL sat_pos_ov: got %b expected 1", rov(0)); else n_pass++;
    n_total++; if (rf(1) !== neg_min) $display("FAIL sat_neg_f: got %h expected %h", rf(1), neg_min); else n_pass++;
    n_total++; if (rov(1) !== 1'b1) $display("FAIL sat_neg_ov: got %b expected 1", rov(1)); else n_pass++;
    n_total++; if (rf(2) !== 28'sd4) $display("FAIL sat_after_f: got %0d expected 4", rf(2)); else n_pass++;
    n_total++; if (rov(2) !== 1'b0) $display("FAIL sat_after_ov: got %b expected 0", rov(2)); else n_pass++;
  endtask

  task automatic test_clear();
    bit found;
    valid_in = 1'b1; a = 14'sd7; b = 14'sd7;
    step();
    step();
    clear = 1'b1; a = 14'sd5; b = 14'sd5;
    step();
    clear = 1'b0;
    n_total++; if (f !== 28'sd4) $display("FAIL clear_f_hold: got %0d expected 4", f); else n_pass++;
    n_total++; if (valid_out !== 1'b0) $display("FAIL clear_vo: got %b expected 0", valid_out); else n_pass++;
    a = 14'sd1; b = 14'sd1;
    repeat (3) step();
    valid_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (valid_out === 1'b1) found = 1'b1;
    end
    n_total++; if (found !== 1'b1) $display("FAIL clear_timeout: got no valid_out within 8 cycles, required one"); else n_pass++;
    n_total++; if (f !== 28'sd28) $display("FAIL clear_f: got %0d expected 28", f); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL clear_ov: got %b expected 0", overflow); else n_pass++;
    // clear arriving with a done already registered must not swallow it
    valid_in = 1'b1; a = 14'sd2; b = 14'sd3;
    repeat (4) step();
    valid_in = 1'b0;
    repeat (LAT - 1) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_total++; if (valid_out !== 1'b1) $display("FAIL clear_late_vo: got %b expected 1", valid_out); else n_pass++;
    n_total++; if (f !== 28'sd24) $display("FAIL clear_late_f: got %0d expected 24", f); else n_pass++;
    step();
    n_total++; if (valid_out !== 1'b0) $display("FAIL clear_late_pulse: got %b expected 0", valid_out); else n_pass++;
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 4; i++) begin
      sa[i] = 14'(i + 1);
      sb[i] = 14'sd2;
    end
    sa[4] = -14'sd3;   sb[4] = 14'sd7;
    sa[5] = 14'sd100;  sb[5] = -14'sd2;
    sa[6] = 14'sh2000; sb[6] = 14'sd3;
    sa[7] = 14'sd5;    sb[7] = 14'sd8191;
    run_stream(8, 1'b1);
    n_total++; if (res_f.size() !== 2) $display("FAIL gaps_count: got %0d expected 2", res_f.size()); else n_pass++;
    n_total++; if (rf(0) !== 28'sd20) $display("FAIL gaps_f0: got %0d expected 20", rf(0)); else n_pass++;
    n_total++; if (rf(1) !== 28'sd16158) $display("FAIL gaps_f1: got %0d expected 16158", rf(1)); else n_pass++;
    n_total++; if (rov(1) !== 1'b0) $display("FAIL gaps_ov: got %b expected 0", rov(1)); else n_pass++;
    n_total++; if ((rt(1) - term_t[7]) !== LAT) $display("FAIL gaps_latency: got %0d expected %0d", rt(1) - term_t[7], LAT); else n_pass++;
  endtask

  task automatic test_reset_mid();
    valid_in = 1'b1; a = 14'sd9; b = 14'sd9;
    step();
    step();
    valid_in = 1'b0;
    reset = 1'b1;
    step();
    n_total++; if (f !== 28'sd0) $display("FAIL rstmid_f: got %0d expected 0", f); else n_pass++;
    n_total++; if (valid_out !== 1'b0) $display("FAIL rstmid_vo: got %b expected 0", valid_out); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL rstmid_ov: got %b expected 0", overflow); else n_pass++;
    reset = 1'b0;
    sa[0] = 14'sd3; sb[0] = -14'sd2;
    sa[1] = -14'sd1; sb[1] = 14'sd5;
    sa[2] = 14'sd7; sb[2] = 14'sd1;
    sa[3] = 14'sd2; sb[3] = 14'sd10;
    run_stream(4, 1'b0);
    n_total++; if (res_f.size() !== 1) $display("FAIL rstmid_count: got %0d expected 1", res_f.size()); else n_pass++;
    n_total++; if (rf(0) !== 28'sd16) $display("FAIL rstmid_f_after: got %0d expected 16", rf(0)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vec_len1();
    test_back_to_back();
    test_saturation();
    test_clear();
    test_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
